// File: rtl/psubsb_if.sv
// Request/response bundle for the packed saturating nibble subtract unit.
interface psubsb_if #(parameter int LANES = 4);
    logic                 start;
    logic [4*LANES-1:0]   a;
    logic [4*LANES-1:0]   b;
    logic                 sat_clr;
    logic                 busy;
    logic                 done;
    logic [4*LANES-1:0]   res;
    logic [LANES-1:0]     sat;

    modport master (output start, a, b, sat_clr, input busy, done, res, sat);
    modport slave  (input start, a, b, sat_clr, output busy, done, res, sat);
endinterface

// File: rtl/psubsb_seq.sv
// Multi-cycle packed signed-saturating subtract, one 4-bit lane per cycle.
// Define PSUBSB_STICKY_EN to make sat flags accumulate until sat_clr.
module psubsb_seq #(
    parameter int LANES = 4
) (
    input  logic      clk,
    input  logic      rst,
    psubsb_if.slave   bus
);
    localparam int W  = 4 * LANES;
    localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t           state_q;
    logic [CW-1:0]    lane_q;
    logic [W-1:0]     a_q, b_q;
    logic [W-1:0]     acc_res_q;
    logic [LANES-1:0] acc_sat_q;
    logic [W-1:0]     res_q;
    logic [LANES-1:0] sat_q;
    logic             busy_q, done_q;

    logic [3:0]       la, lb, ld, lr;
    logic             lovf;
    logic [W-1:0]     res_nx;
    logic [LANES-1:0] sat_nx;
    logic [LANES-1:0] sat_d;
    logic             last;

    // Shared lane subtractor; the lane result is merged into the accumulators.
    always_comb begin
        la     = a_q[lane_q*4 +: 4];
        lb     = b_q[lane_q*4 +: 4];
        ld     = la + ~lb + 4'd1;
        lovf   = (la[3] != lb[3]) && (ld[3] != la[3]);
        lr     = lovf ? (la[3] ? 4'h8 : 4'h7) : ld;
        res_nx = acc_res_q;
        res_nx[lane_q*4 +: 4] = lr;
        sat_nx = acc_sat_q;
        sat_nx[lane_q] = lovf;
    end

    assign last = (state_q == S_BUSY) && (lane_q == CW'(LANES - 1));

`ifdef PSUBSB_STICKY_EN
    // Clear takes effect before the OR when both land on the same edge.
    always_comb begin
        sat_d = sat_q;
        if (last)
            sat_d = (bus.sat_clr ? '0 : sat_q) | sat_nx;
        else if (bus.sat_clr)
            sat_d = '0;
    end
`else
    logic unused_sat_clr;
    assign unused_sat_clr = bus.sat_clr;

    always_comb begin
        sat_d = sat_q;
        if (last)
            sat_d = sat_nx;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            lane_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_res_q <= '0;
            acc_sat_q <= '0;
            res_q     <= '0;
            sat_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            sat_q  <= sat_d;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        lane_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_BUSY;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    acc_res_q <= res_nx;
                    acc_sat_q <= sat_nx;
                    if (last) begin
                        res_q   <= res_nx;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        lane_q  <= lane_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.res  = res_q;
    assign bus.sat  = sat_q;
endmodule

// File: tb/tb_psubsb_seq.sv
// Self-checking bench for psubsb_seq: directed table, handshake/reset corners,
// sticky-flag sequence and randomized ops against a lane-arithmetic model.
module tb_psubsb_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [3:0] acc_sat = 4'b0;

    psubsb_if #(.LANES(4)) bus ();

    psubsb_seq #(.LANES(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [3:0]  sat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: signed integer difference per lane, clamped to [-8,7].
    function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] r, output logic [3:0] f);
        for (int i = 0; i < 4; i++) begin
            logic signed [3:0] sa, sb;
            int d;
            sa = a[i*4 +: 4];
            sb = b[i*4 +: 4];
            d  = int'(sa) - int'(sb);
            f[i] = 1'b0;
            if (d > 7) begin
                r[i*4 +: 4] = 4'h7; f[i] = 1'b1;
            end else if (d < -8) begin
                r[i*4 +: 4] = 4'h8; f[i] = 1'b1;
            end else begin
                r[i*4 +: 4] = 4'(d);
            end
        end
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        acc_sat = 4'b0;
    endtask

    // Starts at a negedge with the unit idle; returns at the negedge after done.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] er, input logic [3:0] ef, input string name);
        int nb, t;
        logic [3:0] es;
`ifdef PSUBSB_STICKY_EN
        es = acc_sat | ef;
`else
        es = ef;
`endif
        acc_sat = es;
        bus.a = a; bus.b = b; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = 16'($urandom);
        bus.b = 16'($urandom);
        nb = 0; t = 0;
        while (bus.done !== 1'b1 && t < 20) begin
            if (bus.busy === 1'b1) nb++;
            t++;
            @(negedge clk);
        end
        chk({name, " done_seen"}, 32'(bus.done), 32'd1);
        chk({name, " busy_cycles"}, 32'(nb), 32'd4);
        chk({name, " res"}, 32'(bus.res), 32'(er));
        chk({name, " sat"}, 32'(bus.sat), 32'(es));
        @(negedge clk);
    endtask

    vec_t tbl[4];

    initial begin
        logic [15:0] ra, rb, er;
        logic [3:0]  ef;
        int t, dn;

        tbl[0] = '{a: 16'h1234, b: 16'h1111, res: 16'h0123, sat: 4'b0000};
        tbl[1] = '{a: 16'h7080, b: 16'h8101, res: 16'h7F8F, sat: 4'b1000};
        tbl[2] = '{a: 16'h8888, b: 16'h1111, res: 16'h8888, sat: 4'b1111};
        tbl[3] = '{a: 16'h0000, b: 16'h8888, res: 16'h7777, sat: 4'b1111};

        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.sat_clr = 1'b0;
        do_reset();
        chk("reset res",  32'(bus.res),  32'h0);
        chk("reset sat",  32'(bus.sat),  32'h0);
        chk("reset busy", 32'(bus.busy), 32'h0);
        chk("reset done", 32'(bus.done), 32'h0);

        for (int i = 0; i < 4; i++)
            run_op(tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].sat, $sformatf("tbl%0d", i));

        // Start while busy is ignored; start held in the done cycle is accepted.
        do_reset();
        bus.a = 16'h1234; bus.b = 16'h1111; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.a = 16'hFFFF; bus.b = 16'h0001; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        t = 0;
        while (bus.done !== 1'b1 && t < 20) begin t++; @(negedge clk); end
        chk("hs done_seen", 32'(bus.done), 32'd1);
        chk("hs ignored res", 32'(bus.res), 32'h0123);
        bus.a = 16'h7080; bus.b = 16'h8101; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b accepted", 32'(bus.busy), 32'd1);
        chk("b2b res held", 32'(bus.res), 32'h0123);
        t = 1;
        @(negedge clk);
        while (bus.done !== 1'b1 && t < 20) begin t++; @(negedge clk); end
        chk("b2b latency", 32'(t), 32'd4);
        chk("b2b res", 32'(bus.res), 32'h7F8F);
        @(negedge clk);

        // Reset on the second busy cycle abandons the op.
        do_reset();
        run_op(16'h1234, 16'h1111, 16'h0123, 4'b0000, "pre_rst");
        bus.a = 16'h7080; bus.b = 16'h8101; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        acc_sat = 4'b0;
        chk("midrst busy", 32'(bus.busy), 32'h0);
        chk("midrst done", 32'(bus.done), 32'h0);
        chk("midrst res",  32'(bus.res),  32'h0);
        chk("midrst sat",  32'(bus.sat),  32'h0);
        dn = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.done === 1'b1 || bus.busy === 1'b1) dn++;
            @(negedge clk);
        end
        chk("midrst no_done", 32'(dn), 32'h0);

        // Sticky flag sequence.
        do_reset();
        run_op(16'h7000, 16'h8000, 16'h7000, 4'b1000, "stk1");
        run_op(16'h0008, 16'h0001, 16'h0008, 4'b0001, "stk2");
`ifdef PSUBSB_STICKY_EN
        chk("sticky or", 32'(bus.sat), 32'b1001);
`else
        chk("sticky or", 32'(bus.sat), 32'b0001);
`endif
        bus.sat_clr = 1'b1;
        @(negedge clk);
        bus.sat_clr = 1'b0;
`ifdef PSUBSB_STICKY_EN
        chk("sticky clr", 32'(bus.sat), 32'b0000);
        acc_sat = 4'b0;
`else
        chk("sticky clr", 32'(bus.sat), 32'b0001);
`endif
        run_op(16'h7000, 16'h8000, 16'h7000, 4'b1000, "stk3");
        bus.sat_clr = 1'b1;
        acc_sat = 4'b0;
        run_op(16'h0008, 16'h0001, 16'h0008, 4'b0001, "clr_done");
        bus.sat_clr = 1'b0;

        // Randomized ops against the model.
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            model(ra, rb, er, ef);
            run_op(ra, rb, er, ef, $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
